// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one bit per clock, LSB first, fixed WIDTH+1 cycle latency.
// Optional feature: define SERIAL_ADDSUB_OVF_EN to produce the signed overflow flag.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             op_q, op_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             bx_s, sum_s, carry_s;

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    busy_d   = 1'b0;
    done_d   = (state_q == DONE) ? 1'b1 : 1'b0;

    bx_s    = b_q[0] ^ op_q;
    sum_s   = a_q[0] ^ bx_s ^ c_q;
    carry_s = (a_q[0] & bx_s) | (bx_s & c_q) | (c_q & a_q[0]);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          a_d     = a;
          b_d     = b;
          op_d    = op;
          c_d     = op;
          cnt_d   = {CW{1'b0}};
          sh_d    = {WIDTH{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        c_d   = carry_s;
        sh_d  = {sum_s, sh_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == LAST_BIT) begin
          // Last bit: c_q is the carry into the MSB, carry_s the carry out of it.
          state_d  = DONE;
          result_d = {sum_s, sh_q[WIDTH-1:1]};
          cout_d   = carry_s;
`ifdef SERIAL_ADDSUB_OVF_EN
          ovf_d    = c_q ^ carry_s;
`else
          ovf_d    = 1'b0;
`endif
        end else begin
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      op_q     <= 1'b0;
      c_q      <= 1'b0;
      cnt_q    <= {CW{1'b0}};
      sh_q     <= {WIDTH{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= {WIDTH{1'b0}};
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Randomised self-checking bench for serial_addsub (WIDTH=8) against an arithmetic reference model.
module tb_serial_addsub;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         op;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;

  int n_checks = 0;
  int n_errors = 0;

  serial_addsub #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .op       (op),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain modulo arithmetic and signed-range reasoning.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mop,
                       output logic [W-1:0] r, output logic c, output logic v);
    int sa, sb, sr;
    sa = ma[W-1] ? int'(ma) - (1 << W) : int'(ma);
    sb = mb[W-1] ? int'(mb) - (1 << W) : int'(mb);
    if (mop) begin
      r  = ma - mb;
      c  = (ma >= mb);
      sr = sa - sb;
    end else begin
      r  = ma + mb;
      c  = ((int'(ma) + int'(mb)) >= (1 << W));
      sr = sa + sb;
    end
`ifdef SERIAL_ADDSUB_OVF_EN
    v = (sr > ((1 << (W - 1)) - 1)) || (sr < -(1 << (W - 1)));
`else
    v = 1'b0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for done, returning the number of edges it took (limit+1 if never seen).
  task automatic wait_done(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n <= limit);
  endtask

  task automatic check_outputs(input string tag, input logic [W-1:0] ea, input logic [W-1:0] eb,
                               input logic eop);
    logic [W-1:0] er;
    logic ec, ev;
    model(ea, eb, eop, er, ec, ev);
    chk({tag, ".result"}, 64'(result), 64'(er));
    chk({tag, ".cout"}, 64'(cout), 64'(ec));
    chk({tag, ".overflow"}, 64'(overflow), 64'(ev));
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic top);
    int n;
    logic [W-1:0] held;
    start = 1'b1; a = ta; b = tb; op = top;
    tick();
    start = 1'b0; a = $urandom; b = $urandom; op = $urandom_range(0, 1);
    chk({tag, ".busy"}, 64'(busy), 64'd1);
    wait_done(20, n);
    chk({tag, ".latency"}, 64'(n), 64'(W + 1));
    check_outputs(tag, ta, tb, top);
    held = result;
    tick();
    chk({tag, ".done_pulse"}, 64'(done), 64'd0);
    chk({tag, ".idle_busy"}, 64'(busy), 64'd0);
    chk({tag, ".held"}, 64'(result), 64'(held));
  endtask

  initial begin
    int n, pulses, first_at;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; op = 1'b0;
    tick();
    start = 1'b1; a = 8'hFF; b = 8'hFF;
    tick();
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.done", 64'(done), 64'd0);
    chk("reset.result", 64'(result), 64'd0);
    chk("reset.cout", 64'(cout), 64'd0);
    chk("reset.overflow", 64'(overflow), 64'd0);
    reset = 1'b0; start = 1'b0;
    tick();

    do_op("add", 8'h3C, 8'h05, 1'b0);
    do_op("sub_borrow", 8'h05, 8'h06, 1'b1);
    do_op("sub_noborrow", 8'h06, 8'h05, 1'b1);
    do_op("ovf_add", 8'h7F, 8'h01, 1'b0);
    do_op("ovf_sub", 8'h80, 8'h01, 1'b1);
    do_op("sub_equal", 8'hA5, 8'hA5, 1'b1);
    do_op("add_wrap", 8'hFF, 8'hFF, 1'b0);

    // Start re-asserted mid-run must be ignored.
    start = 1'b1; a = 8'h10; b = 8'h20; op = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick();
    start = 1'b1; a = 8'hFF;
    tick();
    start = 1'b0;
    pulses = 0; first_at = 0;
    for (int i = 4; i <= 20; i++) begin
      if (done) begin
        pulses++;
        if (first_at == 0) first_at = i - 1;
      end
      tick();
    end
    chk("busyprot.pulses", 64'(pulses), 64'd1);
    chk("busyprot.latency", 64'(first_at), 64'(W + 1));
    chk("busyprot.result", 64'(result), 64'h30);

    // Start held through DONE: second operation begins on the done edge.
    start = 1'b1; a = 8'h10; b = 8'h20; op = 1'b0;
    tick();
    a = 8'h01; b = 8'h01;
    wait_done(20, n);
    chk("b2b.lat1", 64'(n), 64'(W + 1));
    chk("b2b.res1", 64'(result), 64'h30);
    chk("b2b.busy_at_done", 64'(busy), 64'd1);
    start = 1'b0; a = $urandom; b = $urandom;
    wait_done(20, n);
    chk("b2b.gap", 64'(n), 64'(W + 1));
    check_outputs("b2b.op2", 8'h01, 8'h01, 1'b0);
    tick();

    // Reset during RUN aborts with no done pulse.
    start = 1'b1; a = 8'h7F; b = 8'h7F; op = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort.busy", 64'(busy), 64'd0);
    chk("abort.result", 64'(result), 64'd0);
    chk("abort.cout", 64'(cout), 64'd0);
    chk("abort.overflow", 64'(overflow), 64'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      pulses += int'(done);
      tick();
    end
    chk("abort.no_done", 64'(pulses), 64'd0);
    do_op("after_abort", 8'h3C, 8'hC4, 1'b1);

    for (int k = 0; k < 40; k++) begin
      do_op("rand", W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 8, as the operand/result width in bits; legal range 2..64.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, a request to begin an operation.
REQ-005 The block SHALL have port a, input, WIDTH, operand A; sampled only on an accepted start.
REQ-006 The block SHALL have port b, input, WIDTH, operand B; sampled only on an accepted start.
REQ-007 The block SHALL have port op, input, 1, the operation select (0 = A+B, 1 = A-B); sampled only on an accepted start.
REQ-008 The block SHALL have port busy, output, 1, high while an operation is in progress.
REQ-009 The block SHALL have port done, output, 1, a one-cycle pulse marking result valid.
REQ-010 The block SHALL have port result, output, WIDTH, the sum or difference.
REQ-011 The block SHALL have port cout, output, 1, the final carry out (for subtract: 1 = no borrow, A>=B unsigned).
REQ-012 The block SHALL have port overflow, output, 1, the two's-complement signed overflow flag.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE.
REQ-014 Transitions SHALL be: IDLE->RUN on start; RUN->DONE after the WIDTH-th bit; DONE->RUN on start; DONE->IDLE otherwise.
REQ-015 An accepted start SHALL latch a, b and op, set the carry register to op, and clear the bit counter.
REQ-016 In RUN, each clock SHALL process exactly one bit i, LSB first.
REQ-017 The bit-i computation SHALL be s = a[i]^b[i]^op^c and c' = a[i]&(b[i]^op) | (b[i]^op)&c | c&a[i].
REQ-018 Each s SHALL be shifted into result from the MSB end, so that result is correctly ordered after WIDTH shifts.
REQ-019 Latency SHALL be fixed: done is high during the single cycle that begins WIDTH+1 rising edges after the edge that sampled start.
REQ-020 busy SHALL be high in RUN only; start is ignored while busy=1, and the latched operands are not disturbed.
REQ-021 start asserted in DONE SHALL be accepted: done still pulses that cycle and the new operation begins on the same edge.
REQ-022 result, cout and overflow SHALL be updated only on entry to DONE and held stable until the next DONE.
REQ-023 Intermediate shift contents SHALL not be visible on result during RUN; the shift uses an internal register.
REQ-024 cout SHALL equal the carry out of bit WIDTH-1.
REQ-025 Arithmetic SHALL be modulo 2^WIDTH, with no saturation.

Reset
REQ-026 When reset=1 at a rising edge, the FSM SHALL go to IDLE, busy=0, done=0, result=0, cout=0, overflow=0, and the counter and carry SHALL clear.
REQ-027 Reset SHALL take priority over start.
REQ-028 Reset asserted mid-RUN SHALL abort the operation without a done pulse.

Configuration
REQ-029 Macro SERIAL_ADDSUB_OVF_EN defined: overflow SHALL be the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1, captured with result.
REQ-030 Macro SERIAL_ADDSUB_OVF_EN undefined: overflow SHALL be constant 0 and the carry-into-MSB register SHALL be omitted; all other behaviour is unchanged.

Verification (WIDTH=8)
REQ-031 Add: a=8'h3C, b=8'h05, op=0, start pulse -> done pulse 9 edges later; result=8'h41, cout=0, overflow=0.
REQ-032 Subtract with borrow: a=8'h05, b=8'h06, op=1 -> result=8'hFF, cout=0, overflow=0; then a=8'h06, b=8'h05 -> result=8'h01, cout=1.
REQ-033 Signed overflow: a=8'h7F, b=8'h01, op=0 -> result=8'h80, cout=0, overflow=1 with SERIAL_ADDSUB_OVF_EN, overflow=0 without it.
REQ-034 Busy protection: start a=8'h10, b=8'h20; re-assert start with a=8'hFF on cycle 3 -> single done pulse, result=8'h30.
REQ-035 Back-to-back: hold start high across DONE with a=8'h01, b=8'h01 -> two done pulses 9 cycles apart, results 8'h30 then 8'h02.
REQ-036 Reset mid-op: assert reset on cycle 4 of RUN -> no done pulse, all outputs 0, and a subsequent start completes correctly.
